// File: rtl/seq_player.sv
// seq_player: plays the stored colour sequence on four one-hot LEDs.
// Each element is shown as WAIT (1 cycle), ON (ON_TICKS), OFF (OFF_TICKS).
// end_FPGA pulses for one cycle once the whole sequence has been shown.
// Optional build macro SEQ_PLAYER_SPEEDUP_EN adds a level[1:0] input that
// shortens the ON/OFF durations by a right shift, clamped to at least 1.
module seq_player #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned ON_TICKS  = 25000000,
  parameter int unsigned OFF_TICKS = 12500000,
  parameter int unsigned TMR_W     = 25
) (
  input  logic              CLOCK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len,
  input  logic [1:0]        seq_data,
`ifdef SEQ_PLAYER_SPEEDUP_EN
  input  logic [1:0]        level,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        leds,
  output logic              busy,
  output logic              end_FPGA
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ON, S_OFF} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W + 1)'(1);

  state_t            state, state_d;
  logic [TMR_W-1:0]  timer, timer_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   len_clamped;
  logic [3:0]        leds_d;
  logic              busy_d, end_d;
  logic [TMR_W-1:0]  on_m1, off_m1;

`ifdef SEQ_PLAYER_SPEEDUP_EN
  logic [1:0] level_q, level_d;

  function automatic logic [TMR_W-1:0] dur_m1(input int unsigned ticks,
                                              input logic [1:0] lvl);
    int unsigned eff;
    eff = ticks >> lvl;
    if (eff == 0) eff = 1;
    return TMR_W'(eff - 1);
  endfunction

  assign on_m1  = dur_m1(ON_TICKS, level_q);
  assign off_m1 = dur_m1(OFF_TICKS, level_q);
`else
  assign on_m1  = TMR_W'(ON_TICKS - 1);
  assign off_m1 = TMR_W'(OFF_TICKS - 1);
`endif

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      idx      <= '0;
      addr     <= '0;
      len_q    <= '0;
      leds     <= '0;
      busy     <= 1'b0;
      end_FPGA <= 1'b0;
`ifdef SEQ_PLAYER_SPEEDUP_EN
      level_q  <= '0;
`endif
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      idx      <= idx_d;
      addr     <= addr_d;
      len_q    <= len_d;
      leds     <= leds_d;
      busy     <= busy_d;
      end_FPGA <= end_d;
`ifdef SEQ_PLAYER_SPEEDUP_EN
      level_q  <= level_d;
`endif
    end
  end

  // Next-state and next-output logic; abort outranks everything outside IDLE.
  always_comb begin
    state_d = state;
    timer_d = timer;
    idx_d   = idx;
    addr_d  = addr;
    len_d   = len_q;
    leds_d  = leds;
    busy_d  = busy;
    end_d   = 1'b0;
`ifdef SEQ_PLAYER_SPEEDUP_EN
    level_d = level_q;
`endif
    if (abort && state != S_IDLE) begin
      state_d = S_IDLE;
      timer_d = '0;
      idx_d   = '0;
      addr_d  = '0;
      leds_d  = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            len_d  = len_clamped;
            idx_d  = '0;
            addr_d = '0;
`ifdef SEQ_PLAYER_SPEEDUP_EN
            level_d = level;
`endif
            if (len_clamped == '0) begin
              busy_d = 1'b0;
              end_d  = 1'b1;
            end else begin
              busy_d  = 1'b1;
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          leds_d  = 4'b0001 << seq_data;
          timer_d = on_m1;
          state_d = S_ON;
        end
        S_ON: begin
          if (timer == '0) begin
            leds_d  = '0;
            timer_d = off_m1;
            state_d = S_OFF;
          end else begin
            timer_d = timer - 1'b1;
          end
        end
        S_OFF: begin
          if (timer == '0) begin
            if ({1'b0, idx} == len_q - ONE_LEN) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              end_d   = 1'b1;
            end else begin
              idx_d   = idx + 1'b1;
              addr_d  = idx + 1'b1;
              state_d = S_WAIT;
            end
          end else begin
            timer_d = timer - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player (default build, ON_TICKS=4, OFF_TICKS=2).
// The reference model derives every output from the elapsed cycle count
// since the start edge, the clamped length and an optional abort edge.
module tb_seq_player;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned ON     = 4;
  localparam int unsigned OFF    = 2;
  localparam int unsigned P      = 1 + ON + OFF;
  localparam int unsigned DEPTH  = 32;

  logic              CLOCK = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   len   = '0;
  logic [1:0]        seq_data;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        leds;
  logic              busy;
  logic              end_FPGA;

  logic [1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  always #5 CLOCK = ~CLOCK;

  assign seq_data = mem[addr];

  seq_player #(
    .ADDR_W   (ADDR_W),
    .ON_TICKS (ON),
    .OFF_TICKS(OFF),
    .TMR_W    (3)
  ) dut (
    .CLOCK   (CLOCK),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .len     (len),
    .seq_data(seq_data),
    .addr    (addr),
    .leds    (leds),
    .busy    (busy),
    .end_FPGA(end_FPGA)
  );

  task automatic check(input string tag, input int t, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Expected outputs after edge t (t=0 is the edge that sampled start).
  // ab>0 is the edge at which abort was sampled.
  task automatic model(input int t, input int n, input int ab,
                       output logic [3:0] e_leds, output logic e_busy,
                       output logic e_end, output logic [ADDR_W-1:0] e_addr);
    int i, r;
    e_leds = '0;
    e_busy = 1'b0;
    e_end  = 1'b0;
    e_addr = '0;
    if (n == 0) begin
      e_end = (t == 0);
      return;
    end
    if (ab > 0 && t >= ab) return;
    if (t < n * P) begin
      i      = t / P;
      r      = t % P;
      e_busy = 1'b1;
      e_addr = ADDR_W'(i);
      if (r >= 1 && r <= ON) e_leds = 4'(1) << mem[i];
    end else begin
      e_end  = (t == n * P);
      e_addr = ADDR_W'(n - 1);
    end
  endtask

  task automatic compare_all(input int t, input int n, input int ab);
    logic [3:0]        e_leds;
    logic              e_busy, e_end;
    logic [ADDR_W-1:0] e_addr;
    model(t, n, ab, e_leds, e_busy, e_end, e_addr);
    check("leds", t, 32'(leds), 32'(e_leds));
    check("busy", t, 32'(busy), 32'(e_busy));
    check("end_FPGA", t, 32'(end_FPGA), 32'(e_end));
    check("addr", t, 32'(addr), 32'(e_addr));
  endtask

  task automatic fill_mem();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 2'($urandom_range(0, 3));
  endtask

  // One playback from IDLE; noise injects start pulses / len changes while busy.
  task automatic play(input int len_in, input int ab, input bit noise);
    int n, tt;
    n  = (len_in > int'(DEPTH)) ? int'(DEPTH) : len_in;
    tt = n * int'(P);
    len   = (ADDR_W + 1)'(len_in);
    start = 1'b1;
    abort = 1'b0;
    @(posedge CLOCK); #1;
    start = 1'b0;
    compare_all(0, n, ab);
    for (int t = 1; t <= tt + 2; t++) begin
      abort = (ab > 0 && t == ab);
      if (noise && t <= tt && (ab == 0 || t <= ab) && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        len   = (ADDR_W + 1)'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge CLOCK); #1;
      compare_all(t, n, ab);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    fill_mem();
    // Reset state
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_leds", 0, 32'(leds), 32'h0);
    check("rst_busy", 0, 32'(busy), 32'h0);
    check("rst_end", 0, 32'(end_FPGA), 32'h0);
    check("rst_addr", 0, 32'(addr), 32'h0);
    @(negedge CLOCK) reset = 1'b1;
    @(negedge CLOCK);

    // Sequence 2,0,3
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    play(3, 0, 1'b0);

    // Zero length: immediate end pulse, never busy
    play(0, 0, 1'b0);

    // Abort mid-playback, then replay from address 0
    play(3, 10, 1'b0);
    play(3, 0, 1'b0);

    // Start held high across a whole playback of one element
    len   = (ADDR_W + 1)'(1);
    start = 1'b1;
    @(posedge CLOCK); #1;
    compare_all(0, 1, 0);
    for (int t = 1; t <= int'(P); t++) begin
      @(posedge CLOCK); #1;
      compare_all(t, 1, 0);
    end
    @(posedge CLOCK); #1;
    check("held_busy", int'(P) + 1, 32'(busy), 32'h1);
    check("held_addr", int'(P) + 1, 32'(addr), 32'h0);
    check("held_end", int'(P) + 1, 32'(end_FPGA), 32'h0);
    start = 1'b0;
    abort = 1'b1;
    @(posedge CLOCK); #1;
    abort = 1'b0;
    check("held_abort_busy", int'(P) + 2, 32'(busy), 32'h0);
    @(negedge CLOCK);

    // Asynchronous reset while an element is lit
    mem[0] = 2'd1;
    len    = (ADDR_W + 1)'(1);
    start  = 1'b1;
    @(posedge CLOCK); #1;
    start = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    compare_all(2, 1, 0);
    #2 reset = 1'b0;
    #1;
    check("arst_leds", 2, 32'(leds), 32'h0);
    check("arst_busy", 2, 32'(busy), 32'h0);
    check("arst_addr", 2, 32'(addr), 32'h0);
    @(negedge CLOCK) reset = 1'b1;
    @(negedge CLOCK);
    play(1, 0, 1'b0);

    // Length beyond memory depth is clamped
    fill_mem();
    play(37, 0, 1'b0);

    // Randomized playbacks with aborts, stray starts and len changes
    for (int k = 0; k < 12; k++) begin
      int len_in, n, ab;
      fill_mem();
      len_in = $urandom_range(0, 40);
      n      = (len_in > int'(DEPTH)) ? int'(DEPTH) : len_in;
      ab     = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n * P) : 0;
      play(len_in, ab, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
